mux_4_1_rr: RTL and testbench



---
 rtl/mux_4_1_rr.sv | 95 +++++++++
 tb/tb_mux_4_1_rr.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mux_4_1_rr.sv
// Registered 4-to-1 valid/ready stream merger with round-robin arbitration.
// Each output beat is tagged with the index of the lane that supplied it.
module mux_4_1_rr #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          in_valid,
    input  logic [4*DATA_W-1:0] in_data,
    output logic [3:0]          in_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_sel,
    input  logic                out_ready
);

    logic [1:0]        last_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic [1:0]        out_sel_r;

    logic              can_load_s;
    logic              grant_valid_s;
    logic [1:0]        grant_s;
    logic [DATA_W-1:0] grant_data_s;

    // Output register may accept a new beat when empty or being drained this cycle.
    always_comb begin
        can_load_s = ~out_valid_r | out_ready;
    end

    // Round-robin search starting one lane past the last accepted grant.
    always_comb begin : arbiter
        logic [1:0] idx;
        grant_valid_s = 1'b0;
        grant_s       = 2'b00;
        idx           = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            idx = last_r + 2'(k);
            if (!grant_valid_s && in_valid[idx]) begin
                grant_valid_s = 1'b1;
                grant_s       = idx;
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Select the granted lane's data word.
    always_comb begin
        grant_data_s = {DATA_W{1'b0}};
        case (grant_s)
            2'd0:    grant_data_s = in_data[0*DATA_W +: DATA_W];
            2'd1:    grant_data_s = in_data[1*DATA_W +: DATA_W];
            2'd2:    grant_data_s = in_data[2*DATA_W +: DATA_W];
            2'd3:    grant_data_s = in_data[3*DATA_W +: DATA_W];
            default: grant_data_s = {DATA_W{1'b0}};
        endcase
    end

    // Ready goes only to the granted lane; held low during reset.
    always_comb begin
        in_ready = 4'b0000;
        if (!rst && grant_valid_s && can_load_s) begin
            in_ready[grant_s] = 1'b1;
        end else begin
            in_ready = 4'b0000;
        end
    end

    // Output beat register and last-grant pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_sel_r   <= 2'b00;
            last_r      <= 2'b11;
        end else if (grant_valid_s && can_load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= grant_data_s;
            out_sel_r   <= grant_s;
            last_r      <= grant_s;
        end else if (out_ready) begin
            // Drained with nothing to replace it: data and tag stay as they were.
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_mux_4_1_rr.sv
// Self-checking bench for mux_4_1_rr: directed scenarios followed by random
// traffic, all checked against a lane-level behavioural model.
module tb_mux_4_1_rr;

    localparam int DATA_W = 8;

    logic                clk;
    logic                rst;
    logic [3:0]          in_valid;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          in_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_sel;
    logic                out_ready;

    int checks = 0;
    int errors = 0;

    // Model state: what the output should hold and which lane was last served.
    int             m_last  = 3;
    bit             m_valid = 1'b0;
    logic [7:0]     m_data  = 8'h00;
    int             m_sel   = 0;

    mux_4_1_rr #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requesting lane after 'last' in circular order, or -1.
    function automatic int pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [7:0] lane_data(input int lane);
        logic [4*DATA_W-1:0] d;
        d = in_data;
        return d[lane*DATA_W +: DATA_W];
    endfunction

    task automatic set_lanes(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
        in_valid = v;
        in_data  = {d3, d2, d1, d0};
    endtask

    // One clock: check ready mid-cycle, advance model on the edge, check outputs after it.
    task automatic cycle(input string tag);
        int         g;
        bit         can_load;
        logic [3:0] exp_rdy;
        #4;
        can_load = !m_valid || out_ready;
        g        = pick(in_valid, m_last);
        exp_rdy  = 4'b0000;
        if (!rst && g >= 0 && can_load) exp_rdy = 4'(1 << g);
        check({tag, ".in_ready"}, {28'd0, in_ready}, {28'd0, exp_rdy});
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = 8'h00; m_sel = 0; m_last = 3;
        end else if (g >= 0 && can_load) begin
            m_valid = 1'b1; m_data = lane_data(g); m_sel = g; m_last = g;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
        check({tag, ".out_data"},  {24'd0, out_data},  {24'd0, m_data});
        check({tag, ".out_sel"},   {30'd0, out_sel},   32'(m_sel));
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        set_lanes(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk); #1;

        // Reset then idle
        cycle("reset0");
        cycle("reset1");
        check("reset.out_sel_const", {30'd0, out_sel}, 32'd0);
        rst = 1'b0;
        cycle("idle");

        // Single lane 2
        set_lanes(4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00);
        cycle("single");
        check("single.data_const", {24'd0, out_data}, 32'h0000_00A5);
        check("single.sel_const",  {30'd0, out_sel},  32'd2);
        set_lanes(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        cycle("single_drain");

        // Round robin from a fresh pointer
        rst = 1'b1; cycle("rr_reset"); rst = 1'b0;
        set_lanes(4'b1111, 8'h10, 8'h11, 8'h12, 8'h13);
        for (int i = 0; i < 8; i++) begin
            cycle("rr");
            check("rr.sel_seq", {30'd0, out_sel}, 32'(i % 4));
        end

        // Backpressure with lane 1 held
        set_lanes(4'b0010, 8'h00, 8'h3C, 8'h00, 8'h00);
        cycle("bp_load");
        out_ready = 1'b0;
        set_lanes(4'b1001, 8'hC0, 8'h00, 8'h00, 8'hC3);
        for (int i = 0; i < 3; i++) begin
            cycle("bp_stall");
            check("bp.held_data", {24'd0, out_data}, 32'h0000_003C);
        end
        out_ready = 1'b1;
        cycle("bp_rel3");
        check("bp.lane3_first", {30'd0, out_sel}, 32'd3);
        set_lanes(4'b0001, 8'hC0, 8'h00, 8'h00, 8'h00);
        cycle("bp_rel0");
        check("bp.lane0_next", {30'd0, out_sel}, 32'd0);

        // Pointer wrap after lane 3
        set_lanes(4'b1000, 8'h00, 8'h00, 8'h00, 8'h33);
        cycle("wrap3");
        set_lanes(4'b0101, 8'h40, 8'h00, 8'h42, 8'h00);
        cycle("wrap0");
        check("wrap.lane0", {30'd0, out_sel}, 32'd0);
        set_lanes(4'b0100, 8'h40, 8'h00, 8'h42, 8'h00);
        cycle("wrap2");
        check("wrap.lane2", {30'd0, out_sel}, 32'd2);

        // Reset during a stall
        out_ready = 1'b0;
        set_lanes(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        cycle("mid_stall");
        rst = 1'b1;
        set_lanes(4'b0011, 8'h50, 8'h51, 8'h00, 8'h00);
        cycle("mid_rst");
        check("mid_rst.valid_const", {31'd0, out_valid}, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        cycle("mid_after");
        check("mid_after.lane0", {30'd0, out_sel}, 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = 4'($urandom);
            in_data   = 32'($urandom);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
